// File: rtl/sw_pkg.sv
// Shared Smith-Waterman encodings: base codes, biased-zero helper, PE and feeder state types.
package sw_pkg;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'b00;
  localparam base_t BASE_G = 2'b01;
  localparam base_t BASE_T = 2'b10;
  localparam base_t BASE_C = 2'b11;

  // Processing-element control states, shared with the PE array.
  typedef enum logic [1:0] {
    PE_WAIT = 2'd0,
    PE_CALC = 2'd1,
    PE_HOLD = 2'd2
  } pe_state_e;

  typedef enum logic [3:0] {
    ST_LOAD   = 4'b0001,
    ST_GAP    = 4'b0010,
    ST_STREAM = 4'b0100,
    ST_DRAIN  = 4'b1000
  } feed_state_e;

  // Scores are stored offset-binary: the midpoint code represents zero.
  function automatic int sw_zero(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/sw_target_feeder_if.sv
// Upstream valid/ready stream of target bases into the feeder.
interface sw_target_feeder_if;
  import sw_pkg::*;

  logic  s_valid;
  logic  s_ready;
  base_t s_base;
  logic  s_last;

  modport master (output s_valid, s_base, s_last, input s_ready);
  modport slave  (input s_valid, s_base, s_last, output s_ready);
endinterface

// File: rtl/sw_base_buffer.sv
// Simple dual-port base RAM: synchronous write, registered read with one cycle of latency.
module sw_base_buffer
  import sw_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  base_t         wdata,
  input  logic [AW-1:0] raddr,
  output base_t         rdata
);

  base_t mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sw_target_feeder.sv
// Buffers one target sequence, then replays it into PE 0 as a single bubble-free burst
// and waits for the array to drain before taking the next sequence.
module sw_target_feeder
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = 12,
  parameter int MAX_LEN     = 256,
  parameter int N_PE        = 64,
  parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  sw_target_feeder_if.slave      up,
  output logic                   pe_en,
  output base_t                  pe_data,
  output logic [SCORE_WIDTH-1:0] pe_M,
  output logic [SCORE_WIDTH-1:0] pe_I,
  output logic [SCORE_WIDTH-1:0] pe_High,
  input  logic                   array_vld,
  output logic [LEN_W-1:0]       seq_len,
  output logic                   busy,
  output logic                   done,
  output logic                   trunc,
  output logic                   err
);

  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(sw_zero(SCORE_WIDTH));
  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int WD_W = $clog2(N_PE + 4);

  feed_state_e      state, state_nx;
  logic             ready_nx, en_nx, busy_nx, done_nx, trunc_nx, err_nx;
  base_t            data_nx, head, head_nx, rd_base;
  logic [LEN_W-1:0] wr_ptr, wr_nx, rd_ptr, rd_nx, len_nx;
  logic [WD_W-1:0]  wd, wd_nx;
  logic [AW-1:0]    raddr;
  logic             accept;

  assign pe_M    = ZERO;
  assign pe_I    = ZERO;
  assign pe_High = ZERO;

  assign accept = (state == ST_LOAD) && up.s_valid && up.s_ready;

  // rd_ptr counts bases already sent; the RAM is always one base ahead of pe_data.
  // Base 0 comes from head so the burst can start right after GAP.
  assign raddr = AW'(rd_ptr + LEN_W'(1));

  sw_base_buffer #(.AW(AW)) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (AW'(wr_ptr)),
    .wdata (up.s_base),
    .raddr (raddr),
    .rdata (rd_base)
  );

  always_comb begin
    state_nx = state;
    ready_nx = 1'b0;
    en_nx    = 1'b0;
    data_nx  = BASE_A;
    len_nx   = seq_len;
    done_nx  = 1'b0;
    trunc_nx = trunc;
    err_nx   = err;
    wr_nx    = wr_ptr;
    rd_nx    = rd_ptr;
    wd_nx    = wd;
    head_nx  = head;
    unique case (state)
      ST_LOAD: begin
        ready_nx = 1'b1;
        if (accept) begin
          wr_nx = wr_ptr + LEN_W'(1);
          if (wr_ptr == '0) head_nx = up.s_base;
          if (up.s_last || wr_ptr == LEN_W'(MAX_LEN - 1)) begin
            len_nx   = wr_ptr + LEN_W'(1);
            ready_nx = 1'b0;
            rd_nx    = '0;
            state_nx = ST_GAP;
            if (!up.s_last) trunc_nx = 1'b1;
          end
        end
      end
      ST_GAP: begin
        en_nx    = 1'b1;
        data_nx  = head;
        rd_nx    = LEN_W'(1);
        state_nx = ST_STREAM;
      end
      ST_STREAM: begin
        if (rd_ptr == seq_len) begin
          wd_nx    = '0;
          state_nx = ST_DRAIN;
        end else begin
          en_nx   = 1'b1;
          data_nx = rd_base;
          rd_nx   = rd_ptr + LEN_W'(1);
        end
      end
      ST_DRAIN: begin
        if (array_vld) begin
          done_nx  = 1'b1;
          trunc_nx = 1'b0;
          wr_nx    = '0;
          state_nx = ST_LOAD;
        end else if (wd == WD_W'(N_PE + 3)) begin
          err_nx   = 1'b1;
          wr_nx    = '0;
          state_nx = ST_LOAD;
        end else begin
          wd_nx = wd + WD_W'(1);
        end
      end
      default: state_nx = ST_LOAD;
    endcase
    busy_nx = (state_nx != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_LOAD;
      up.s_ready <= 1'b0;
      pe_en      <= 1'b0;
      pe_data    <= BASE_A;
      seq_len    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trunc      <= 1'b0;
      err        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wd         <= '0;
    end else begin
      state      <= state_nx;
      up.s_ready <= ready_nx;
      pe_en      <= en_nx;
      pe_data    <= data_nx;
      seq_len    <= len_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      trunc      <= trunc_nx;
      err        <= err_nx;
      wr_ptr     <= wr_nx;
      rd_ptr     <= rd_nx;
      wd         <= wd_nx;
    end
  end

  always_ff @(posedge clk) begin
    head <= head_nx;
  end

endmodule
